pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage MIPS pipeline (branches and
// jumps resolve in MEM). It resolves, in priority order:
//   ERR > data-memory freeze > MEM redirect > load-use interlock
//   > instruction-memory wait > normal flow.
// The outputs are the enable and flush controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   ID_rs/ID_rt/ID_uses_rs/_rt   source operands of the instruction in ID
//   EX_MemtoReg, EX_Rw           load flag and destination of the EX instruction
//   MEM_take                     taken branch/jump sitting in MEM
//   MEM_memop, dmem_ready        data-memory access in MEM and its completion
//   imem_ready                   instruction fetch data valid
//   pc_en, pc_redirect           PC load enable / load MEM_npc
//   *_en, *_flush, MEMWB_bubble  pipeline register enables and bubble loads
//   state                        00 RUN, 01 WAIT, 10 ERR
//   bus_err                      sticky data-memory timeout flag
//   stall_cnt, flush_cnt         saturating performance counters
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DMEM_TIMEOUT = 255,
    parameter int WAIT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             EX_MemtoReg,
    input  logic [4:0]       EX_Rw,
    input  logic             MEM_take,
    input  logic             MEM_memop,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             MEMWB_bubble,
    output logic [1:0]       state,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze_s;
    logic redirect_s;
    logic loaduse_s;
    logic iwait_s;

    // Hazard conditions from the current inputs and state.
    always_comb begin
        freeze_s   = (state_q != ST_ERR) & MEM_memop & ~dmem_ready;
        redirect_s = MEM_take & ~freeze_s;
        // Register 0 is hardwired, so a load "to" $0 never creates a hazard.
        loaduse_s  = EX_MemtoReg & (EX_Rw != 5'd0) &
                     ((ID_uses_rs & (ID_rs == EX_Rw)) |
                      (ID_uses_rt & (ID_rt == EX_Rw)));
        iwait_s    = ~imem_ready;
    end

    // Prioritised enable/flush decode; zero-latency from inputs and state.
    always_comb begin
        pc_en        = 1'b0;
        pc_redirect  = 1'b0;
        IFID_en      = 1'b0;
        IDEX_en      = 1'b0;
        EXMEM_en     = 1'b0;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        EXMEM_flush  = 1'b0;
        MEMWB_bubble = 1'b0;
        if (rst) begin
            // Hold every stage and push bubbles while reset is applied.
            IFID_flush   = 1'b1;
            IDEX_flush   = 1'b1;
            EXMEM_flush  = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (state_q == ST_ERR) begin
            MEMWB_bubble = 1'b1;
        end else if (freeze_s) begin
            // MEM cannot retire; everything upstream holds.
            MEMWB_bubble = 1'b1;
        end else if (redirect_s) begin
            // Kill the three younger instructions; MEM proceeds.
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            IFID_en     = 1'b1;
            IDEX_en     = 1'b1;
            EXMEM_en    = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
        end else if (loaduse_s) begin
            // One bubble into EX: next cycle the load is in MEM and forwards.
            IDEX_en    = 1'b1;
            EXMEM_en   = 1'b1;
            IDEX_flush = 1'b1;
        end else if (iwait_s) begin
            // Fetch not ready: feed a bubble into ID, let older stages drain.
            IFID_en    = 1'b1;
            IDEX_en    = 1'b1;
            EXMEM_en   = 1'b1;
            IFID_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            IFID_en  = 1'b1;
            IDEX_en  = 1'b1;
            EXMEM_en = 1'b1;
        end
    end

    // Data-memory wait state machine with timeout watchdog.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (freeze_s) begin
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d   = ST_ERR;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    // Access withdrawn without completion: nothing to wait on.
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                // Corrupted state encoding is treated as a fatal bus fault.
                state_d   = ST_ERR;
                bus_err_d = 1'b1;
            end
        endcase
    end

    // Saturating stall/flush counters for performance debug.
    always_comb begin
        if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (pc_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, watchdog and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (CNT_W=4, DMEM_TIMEOUT=4).
// The control outputs are packed as
// {pc_en, pc_redirect, IFID_en, IDEX_en, EXMEM_en,
//  IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble}
// and compared against hand-derived constants.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [8:0] C_NORMAL = 9'b1_0_111_000_0;
    localparam logic [8:0] C_LU     = 9'b0_0_011_010_0;
    localparam logic [8:0] C_REDIR  = 9'b1_1_111_111_0;
    localparam logic [8:0] C_IWAIT  = 9'b0_0_111_100_0;
    localparam logic [8:0] C_HOLD   = 9'b0_0_000_000_1;
    localparam logic [8:0] C_RESET  = 9'b0_0_000_111_1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_rs, ID_rt, EX_Rw;
    logic ID_uses_rs, ID_uses_rt, EX_MemtoReg;
    logic MEM_take, MEM_memop, dmem_ready, imem_ready;
    logic pc_en, pc_redirect, IFID_en, IDEX_en, EXMEM_en;
    logic IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble;
    logic [1:0] state;
    logic bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0] ctrl;

    int total_cnt = 0;
    int bad_cnt   = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .EX_MemtoReg(EX_MemtoReg), .EX_Rw(EX_Rw),
        .MEM_take(MEM_take), .MEM_memop(MEM_memop),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_en(pc_en), .pc_redirect(pc_redirect),
        .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
        .MEMWB_bubble(MEMWB_bubble), .state(state), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    assign ctrl = {pc_en, pc_redirect, IFID_en, IDEX_en, EXMEM_en,
                   IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_Rw = 5'd0;
        ID_uses_rs = 1'b0; ID_uses_rt = 1'b0; EX_MemtoReg = 1'b0;
        MEM_take = 1'b0; MEM_memop = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        check_val("rst_ctrl", 32'(ctrl), 32'(C_RESET));
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_buserr", 32'(bus_err), 32'd0);
        check_val("rst_stall", 32'(stall_cnt), 32'd0);
        check_val("rst_flush", 32'(flush_cnt), 32'd0);
        step();
        rst = 1'b0;
        #1;

        // Normal flow.
        check_val("normal_ctrl", 32'(ctrl), 32'(C_NORMAL));
        step();
        check_val("normal_stall", 32'(stall_cnt), 32'd0);

        // Load-use on rs.
        EX_MemtoReg = 1'b1; EX_Rw = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        #1;
        check_val("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
        step();
        check_val("lu_rs_stall", 32'(stall_cnt), 32'd1);

        // Load to $0 never stalls.
        EX_Rw = 5'd0; ID_rs = 5'd0;
        #1;
        check_val("lu_r0_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Load-use on rt.
        ID_uses_rs = 1'b0; ID_uses_rt = 1'b1; ID_rt = 5'd9; EX_Rw = 5'd9;
        #1;
        check_val("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
        step();
        check_val("lu_rt_stall", 32'(stall_cnt), 32'd2);

        // Matching rt that is not read: no stall.
        ID_uses_rt = 1'b0;
        #1;
        check_val("lu_nouse_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Taken branch alone, then coincident with load-use.
        idle_inputs();
        MEM_take = 1'b1;
        #1;
        check_val("br_ctrl", 32'(ctrl), 32'(C_REDIR));
        step();
        check_val("br_flush", 32'(flush_cnt), 32'd1);
        EX_MemtoReg = 1'b1; EX_Rw = 5'd8; ID_rs = 5'd8; ID_uses_rs = 1'b1;
        #1;
        check_val("br_lu_ctrl", 32'(ctrl), 32'(C_REDIR));
        step();
        check_val("br_lu_stall", 32'(stall_cnt), 32'd2);
        check_val("br_lu_flush", 32'(flush_cnt), 32'd2);

        // Data wait: 3 freeze cycles with MEM_take held, redirect on ready.
        idle_inputs();
        MEM_take = 1'b1; MEM_memop = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("dw_ctrl%0d", i), 32'(ctrl), 32'(C_HOLD));
            check_val($sformatf("dw_state%0d", i), 32'(state), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check_val("dw_ready_state", 32'(state), 32'd1);
        check_val("dw_ready_ctrl", 32'(ctrl), 32'(C_REDIR));
        step();
        check_val("dw_end_state", 32'(state), 32'd0);
        check_val("dw_end_stall", 32'(stall_cnt), 32'd5);
        check_val("dw_end_flush", 32'(flush_cnt), 32'd3);

        // Instruction-memory wait for 2 cycles.
        idle_inputs();
        imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("iw_ctrl%0d", i), 32'(ctrl), 32'(C_IWAIT));
            step();
        end
        check_val("iw_stall", 32'(stall_cnt), 32'd7);
        imem_ready = 1'b1;

        // Timeout: ERR after 5 freeze cycles.
        MEM_memop = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("to_ctrl%0d", i), 32'(ctrl), 32'(C_HOLD));
            check_val($sformatf("to_buserr%0d", i), 32'(bus_err), 32'd0);
            step();
        end
        check_val("to_state", 32'(state), 32'd2);
        check_val("to_buserr", 32'(bus_err), 32'd1);
        check_val("to_stall", 32'(stall_cnt), 32'd12);

        // ERR ignores everything, even a taken branch and a completed access.
        MEM_memop = 1'b0; MEM_take = 1'b1; dmem_ready = 1'b1;
        #1;
        check_val("err_ctrl", 32'(ctrl), 32'(C_HOLD));
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check_val("err_state", 32'(state), 32'd2);
        check_val("err_stall_sat", 32'(stall_cnt), 32'd15);
        check_val("err_flush", 32'(flush_cnt), 32'd3);

        // Asynchronous reset out of ERR, mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_buserr", 32'(bus_err), 32'd0);
        check_val("arst_stall", 32'(stall_cnt), 32'd0);
        check_val("arst_ctrl", 32'(ctrl), 32'(C_RESET));
        step();
        rst = 1'b0;
        idle_inputs();

        // Saturation: 20 fetch-wait cycles.
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 9) begin
                check_val("sat_mid", 32'(stall_cnt), 32'd10);
            end
        end
        check_val("sat_stall", 32'(stall_cnt), 32'd15);
        check_val("sat_flush", 32'(flush_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
